pc_seq_ras: RTL and testbench

- Parametrised program-counter sequencer for the unpipelined processor; the successor to the single-width step PC.
- Produces the fetch address from sequential, branch, jump, call and return requests.
- Supports free-running and single-step (button) modes, plus a stall input.
- Holds an internal circular return-address stack (RAS) for Call/Ret.

---
 rtl/pc_seq_ras.sv | 150 +++++++++++++++
 tb/tb_pc_seq_ras.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_seq_ras.sv
// Program-counter sequencer with run / single-step / stall control and a
// circular return-address stack serving Call and Ret.
module pc_seq_ras #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int                STEP      = 4,
    parameter int                RAS_DEPTH = 4,
    parameter int                RAS_PTR_W = 2
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Run,
    input  logic              StepBtn,
    input  logic              Stall,
    input  logic              Branch,
    input  logic              BranchTaken,
    input  logic [ADDR_W-1:0] BranchTarget,
    input  logic              Jump,
    input  logic              Call,
    input  logic [ADDR_W-1:0] JumpTarget,
    input  logic              Ret,
    output logic [ADDR_W-1:0] Q,
    output logic              Valid,
    output logic              RasEmpty,
    output logic              RasFull,
    output logic              RasUnderflow,
    output logic [1:0]        o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RUN       = 2'd1,
        S_STEP_HOLD = 2'd2
    } state_t;

    localparam logic [RAS_PTR_W:0] DEPTH_C = (RAS_PTR_W + 1)'(RAS_DEPTH);
    localparam logic [ADDR_W-1:0]  STEP_C  = ADDR_W'(STEP);

    state_t              r_state;
    logic                r_step_d;
    logic [ADDR_W-1:0]   r_ras [RAS_DEPTH];
    logic [RAS_PTR_W-1:0] r_ptr;
    logic [RAS_PTR_W:0]  r_count;

    logic                w_step_req;
    logic                w_adv;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   w_seq;
    logic [RAS_PTR_W-1:0] w_top_idx;
    logic                w_ras_empty;
    logic [ADDR_W-1:0]   w_q_nxt;
    logic                w_push;
    logic                w_pop;
    logic                w_replace;
    logic                w_uf_set;

    assign w_step_req  = StepBtn & ~r_step_d;
    assign w_seq       = Q + STEP_C;
    assign w_top_idx   = r_ptr - 1'b1;
    assign w_ras_empty = (r_count == '0);

    assign RasEmpty    = w_ras_empty;
    assign RasFull     = (r_count == DEPTH_C);
    assign o_dbg_state = r_state;

    // A stalled cycle freezes the mode as well as the PC; a step press seen
    // during a stall is simply lost.
    always_comb begin
        w_adv       = 1'b0;
        w_state_nxt = r_state;
        if (!Stall) begin
            case (r_state)
                S_IDLE: begin
                    if (Run) begin
                        w_state_nxt = S_RUN;
                    end else if (w_step_req) begin
                        w_adv       = 1'b1;
                        w_state_nxt = S_STEP_HOLD;
                    end
                end
                S_RUN: begin
                    w_adv = 1'b1;
                    if (!Run) w_state_nxt = S_IDLE;
                end
                S_STEP_HOLD: begin
                    if (Run)           w_state_nxt = S_RUN;
                    else if (!StepBtn) w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_q_nxt   = w_seq;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_replace = 1'b0;
        w_uf_set  = 1'b0;
        if (Ret) begin
            if (!w_ras_empty) begin
                w_q_nxt = r_ras[w_top_idx];
                // Ret+Call nets to zero depth change: the link lands in the popped slot.
                if (Call) w_replace = 1'b1;
                else      w_pop     = 1'b1;
            end else begin
                w_uf_set = 1'b1;
                w_push   = Call;
            end
        end else if (Call || Jump) begin
            w_q_nxt = JumpTarget;
            w_push  = Call;
        end else if (Branch && BranchTaken) begin
            w_q_nxt = BranchTarget;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state      <= S_IDLE;
            r_step_d     <= 1'b1;
            Q            <= RESET_VEC;
            Valid        <= 1'b0;
            RasUnderflow <= 1'b0;
            r_ptr        <= '0;
            r_count      <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) r_ras[i] <= '0;
        end else begin
            r_step_d <= StepBtn;
            r_state  <= w_state_nxt;
            Valid    <= w_adv;
            if (w_adv) begin
                Q <= w_q_nxt;
                if (w_uf_set) RasUnderflow <= 1'b1;
                if (w_push) begin
                    // When full this overwrites the oldest entry.
                    r_ras[r_ptr] <= w_seq;
                    r_ptr        <= r_ptr + 1'b1;
                    if (r_count != DEPTH_C) r_count <= r_count + 1'b1;
                end
                if (w_pop) begin
                    r_ptr   <= w_top_idx;
                    r_count <= r_count - 1'b1;
                end
                if (w_replace) r_ras[w_top_idx] <= w_seq;
            end
        end
    end

endmodule

// File: tb/tb_pc_seq_ras.sv
// Bench for pc_seq_ras: directed scenarios pinned with literal values, then
// randomized traffic, all checked every cycle against a queue-based model.
module tb_pc_seq_ras;
  localparam int ADDR_W = 32;
  localparam int STEP = 4;
  localparam int DEPTH = 4;

  logic Clk, Rst, Run, StepBtn, Stall, Branch, BranchTaken, Jump, Call, Ret;
  logic [ADDR_W-1:0] BranchTarget, JumpTarget, Q;
  logic Valid, RasEmpty, RasFull, RasUnderflow;
  logic [1:0] dbg_state;

  pc_seq_ras #(.ADDR_W(ADDR_W), .RESET_VEC('0), .STEP(STEP), .RAS_DEPTH(DEPTH), .RAS_PTR_W(2)) dut (
    .Clk(Clk), .Rst(Rst), .Run(Run), .StepBtn(StepBtn), .Stall(Stall),
    .Branch(Branch), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Jump(Jump), .Call(Call), .JumpTarget(JumpTarget), .Ret(Ret),
    .Q(Q), .Valid(Valid), .RasEmpty(RasEmpty), .RasFull(RasFull),
    .RasUnderflow(RasUnderflow), .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // behavioural model: mode 0 idle, 1 running, 2 waiting for button release
  logic [ADDR_W-1:0] m_q;
  logic [ADDR_W-1:0] exp_q[$];
  bit m_valid, m_uf, m_btn_d, m_known;
  int m_mode;
  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit adv;
    bit step_req;
    logic [ADDR_W-1:0] link;
    adv = 0;
    if (!Rst) begin
      m_known = 1; m_q = '0; m_valid = 0; m_uf = 0; m_btn_d = 1; m_mode = 0;
      exp_q.delete();
      return;
    end
    step_req = StepBtn && !m_btn_d;
    m_btn_d = StepBtn;
    if (!Stall) begin
      if (m_mode == 0) begin
        if (Run) m_mode = 1;
        else if (step_req) begin adv = 1; m_mode = 2; end
      end else if (m_mode == 1) begin
        adv = 1;
        if (!Run) m_mode = 0;
      end else begin
        if (Run) m_mode = 1;
        else if (!StepBtn) m_mode = 0;
      end
    end
    m_valid = adv;
    if (!adv) return;
    link = m_q + STEP;
    if (Ret) begin
      if (exp_q.size() > 0) begin
        m_q = exp_q[$];
        if (Call) exp_q[exp_q.size()-1] = link;
        else void'(exp_q.pop_back());
      end else begin
        m_q = link;
        m_uf = 1;
        if (Call) exp_q.push_back(link);
      end
    end else if (Call || Jump) begin
      m_q = JumpTarget;
      if (Call) exp_q.push_back(link);
    end else if (Branch && BranchTaken) begin
      m_q = BranchTarget;
    end else begin
      m_q = link;
    end
    if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
  endtask

  // one clock: advance model, clock DUT, compare every observable output
  task automatic tick();
    model_step();
    @(posedge Clk);
    #1;
    if (m_known) begin
      chk("q", Q, m_q);
      chk("valid", Valid, m_valid);
      chk("ras_empty", RasEmpty, exp_q.size() == 0);
      chk("ras_full", RasFull, exp_q.size() == DEPTH);
      chk("ras_underflow", RasUnderflow, m_uf);
      chk("state", dbg_state, m_mode);
    end
  endtask

  task automatic clr();
    Stall = 0; Branch = 0; BranchTaken = 0; Jump = 0; Call = 0; Ret = 0;
    BranchTarget = '0; JumpTarget = '0; StepBtn = 0;
  endtask

  task automatic do_reset(input logic run_v);
    clr();
    Run = run_v;
    Rst = 0;
    tick(); tick();
    Rst = 1;
  endtask

  task automatic jump_to(input logic [ADDR_W-1:0] t);
    Jump = 1; JumpTarget = t; tick(); Jump = 0;
  endtask

  task automatic call_to(input logic [ADDR_W-1:0] t);
    Call = 1; JumpTarget = t; tick(); Call = 0;
  endtask

  task automatic ret_once();
    Ret = 1; tick(); Ret = 0;
  endtask

  initial begin
    m_known = 0; m_mode = 0; m_q = '0;
    clr();
    Run = 0; Rst = 0;

    // free run
    do_reset(1'b1);
    chk("lit_reset_q", Q, 32'h0);
    chk("lit_reset_empty", RasEmpty, 1'b1);
    tick();
    chk("lit_run_first", Q, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("lit_run_seq", Q, 32'(4 * i));
      chk("lit_run_valid", Valid, 1'b1);
    end

    // single step: held button advances once
    do_reset(1'b0);
    tick();
    StepBtn = 1;
    tick();
    chk("lit_step1", Q, 32'h4);
    for (int i = 0; i < 4; i++) tick();
    chk("lit_step_hold", Q, 32'h4);
    StepBtn = 0; tick();
    StepBtn = 1; tick();
    chk("lit_step2", Q, 32'h8);
    StepBtn = 0; tick(); tick();
    chk("lit_step_idle", Q, 32'h8);

    // branch / jump priority
    do_reset(1'b1);
    tick();
    Branch = 1; BranchTaken = 0; BranchTarget = 32'h100; tick();
    chk("lit_br_not_taken", Q, 32'h4);
    BranchTaken = 1; tick();
    chk("lit_br_taken", Q, 32'h100);
    Jump = 1; JumpTarget = 32'h200; tick();
    chk("lit_jump_wins", Q, 32'h200);
    clr();

    // nested call / return / underflow
    do_reset(1'b1);
    tick();
    jump_to(32'h10);
    call_to(32'h40);
    chk("lit_call1", Q, 32'h40);
    call_to(32'h80);
    chk("lit_call2", Q, 32'h80);
    ret_once();
    chk("lit_ret1", Q, 32'h44);
    ret_once();
    chk("lit_ret2", Q, 32'h14);
    ret_once();
    chk("lit_ret_uf_q", Q, 32'h18);
    chk("lit_ret_uf", RasUnderflow, 1'b1);
    chk("lit_ret_uf_empty", RasEmpty, 1'b1);

    // RAS overflow overwrites the oldest link
    do_reset(1'b1);
    tick();
    for (int i = 1; i <= 5; i++) call_to(32'(i * 32'h100));
    chk("lit_full", RasFull, 1'b1);
    ret_once(); chk("lit_ovf_ret1", Q, 32'h404);
    ret_once(); chk("lit_ovf_ret2", Q, 32'h304);
    ret_once(); chk("lit_ovf_ret3", Q, 32'h204);
    ret_once(); chk("lit_ovf_ret4", Q, 32'h104);
    chk("lit_ovf_empty", RasEmpty, 1'b1);

    // stall holds everything, then reset mid-run overrides a Call
    call_to(32'h20);
    Stall = 1; Jump = 1; JumpTarget = 32'h999;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lit_stall_q", Q, 32'h20);
      chk("lit_stall_valid", Valid, 1'b0);
      chk("lit_stall_ras", RasEmpty, 1'b0);
    end
    clr();
    Call = 1; JumpTarget = 32'h300; Rst = 0; tick();
    chk("lit_rst_q", Q, 32'h0);
    chk("lit_rst_empty", RasEmpty, 1'b1);
    Rst = 1; Call = 0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      Rst = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 15) == 0) Run = ~Run;
      if ($urandom_range(0, 2) == 0) StepBtn = ~StepBtn;
      Stall = ($urandom_range(0, 4) == 0);
      Branch = ($urandom_range(0, 3) == 0);
      BranchTaken = $urandom_range(0, 1);
      Jump = ($urandom_range(0, 5) == 0);
      Call = ($urandom_range(0, 3) == 0);
      Ret = ($urandom_range(0, 3) == 0);
      BranchTarget = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      JumpTarget = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : $urandom;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
